tenyr_fetch: RTL

Instruction prefetch stage sitting directly upstream of the tenyr core. It generates sequential instruction addresses to a fixed-latency instruction memory and buffers returned words with their addresses in a small FIFO. It presents them to the core through a valid/ready handshake. On a taken jump or halt redirect from the core it flushes all buffered and in-flight words and restarts fetching at the new address.

---
 rtl/tenyr_fetch_if.sv | 33 +++
 rtl/tenyr_fetch.sv | 119 +++++++++++
 2 files changed

// File: rtl/tenyr_fetch_if.sv
// -----------------------------------------------------------------------------
// tenyr_fetch_if
// Bundles the instruction-memory request/return signals, the core-facing
// instruction handshake and the core's redirect/stall controls of the tenyr
// prefetch stage.
//   master : the fetch stage (drives mem_req/mem_addr and insn_*)
//   slave  : the surroundings (memory + core)
// -----------------------------------------------------------------------------
interface tenyr_fetch_if;
  // memory side
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_data;
  // core side
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        insn_valid;
  logic [31:0] insn_data;
  logic [31:0] insn_pc;
  logic        insn_ready;
  logic        stall;

  modport master (
    output mem_req, mem_addr, insn_valid, insn_data, insn_pc,
    input  mem_ready, mem_data, redirect, redirect_pc, insn_ready, stall
  );

  modport slave (
    input  mem_req, mem_addr, insn_valid, insn_data, insn_pc,
    output mem_ready, mem_data, redirect, redirect_pc, insn_ready, stall
  );
endinterface

// File: rtl/tenyr_fetch.sv
// -----------------------------------------------------------------------------
// tenyr_fetch
// Instruction prefetch stage for the tenyr core. Issues sequential word
// addresses to a fixed one-cycle-latency instruction memory, buffers returned
// words together with their fetch address in a DEPTH-entry FIFO and hands
// them to the core over a valid/ready handshake. A redirect from the core
// flushes buffered and in-flight words and restarts fetching at redirect_pc.
// Ports:
//   clk    : clock, all state updates on the rising edge
//   reset  : synchronous, active-high reset
//   bus    : tenyr_fetch_if.master (memory request/return, insn handshake,
//            redirect, stall)
// -----------------------------------------------------------------------------
`ifndef RESETVECTOR
`define RESETVECTOR 32'h0000_1000
`endif

module tenyr_fetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = `RESETVECTOR
) (
  input  logic         clk,
  input  logic         reset,
  tenyr_fetch_if.master bus
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          pend_q, pend_d;
  logic [31:0]   pend_pc_q, pend_pc_d;
  logic          kill_q, kill_d;

  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];

  logic [AW+1:0] used;
  logic          has_credit;
  logic          accept;
  logic          push;
  logic          pop;

  // Entries already buffered plus the one possibly in flight; a request only
  // goes out when its return is guaranteed a slot, so the FIFO never overflows.
  assign used       = {1'b0, count_q} + {{(AW+1){1'b0}}, pend_q};
  assign has_credit = used < (AW+2)'(DEPTH);

  // Deliberately independent of mem_ready to keep the memory handshake free
  // of combinational loops.
  assign bus.mem_req  = !reset && !bus.stall && !bus.redirect && has_credit;
  assign bus.mem_addr = fetch_pc_q;

  assign accept = bus.mem_req && bus.mem_ready;
  // A redirect discards both the word returning this cycle and any pop.
  assign push   = pend_q && !kill_q && !bus.redirect;
  assign pop    = bus.insn_valid && bus.insn_ready && !bus.redirect;

  assign bus.insn_valid = (count_q != '0);
  assign bus.insn_data  = data_mem[rd_ptr_q];
  assign bus.insn_pc    = pc_mem[rd_ptr_q];

  always_comb begin
    fetch_pc_d = accept ? fetch_pc_q + 32'd1 : fetch_pc_q;
    pend_d     = accept;
    pend_pc_d  = accept ? fetch_pc_q : pend_pc_q;
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    kill_d = 1'b0;
    if (bus.redirect) begin
      fetch_pc_d = bus.redirect_pc;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      // Defensive: a return still outstanding after the redirect cycle must
      // never reach the FIFO, so mark it to be dropped when it lands.
      kill_d     = pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      pend_q     <= 1'b0;
      pend_pc_q  <= '0;
      kill_q     <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      pend_q     <= pend_d;
      pend_pc_q  <= pend_pc_d;
      kill_q     <= kill_d;
    end
  end

  // FIFO storage: one write enable per entry, no reset needed since the
  // pointers and count define which entries are live.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (!reset && push && (wr_ptr_q == AW'(gi))) begin
        pc_mem[gi]   <= pend_pc_q;
        data_mem[gi] <= bus.mem_data;
      end
    end
  end

endmodule
